pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch sequencer that produces the fetch stream feeding decode and the branch units.
- Holds the architectural PC and issues one fetch at a time to instruction memory over a valid/ready request plus valid response.
- Presents each fetched instruction with its PC and the fall-through address pc_next.
- Accepts a redirect (taken branch target such as BRQ/jump) back from the branch units and discards any stale in-flight fetch.

---
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Optional FETCH_PERF_CNT_EN adds saturating redirect/stall counters.
module pc_fetch_unit #(
    parameter int              XLEN     = 19,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_next,
    input  logic            instr_ready,
    input  logic            redirect_valid,
`ifdef FETCH_PERF_CNT_EN
    input  logic [XLEN-1:0] redirect_addr,
    output logic [15:0]     perf_redirects,
    output logic [15:0]     perf_stalls
`else
    input  logic [XLEN-1:0] redirect_addr
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic            req_hs;
    logic            pending;
    logic            rsp_take;

    assign req_hs   = imem_req_valid & imem_req_ready;
    assign rsp_take = (state == S_WAIT) & imem_rsp_valid;
    // A fetch is still owed by memory after this edge: reset must drain it.
    assign pending  = req_hs |
                      (((state == S_WAIT) | (state == S_DROP)) & ~imem_rsp_valid);

    always_ff @(posedge clk) begin
        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (en) state_nxt = S_REQ;
            S_REQ: begin
                if (req_hs) state_nxt = redirect_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid)
                    state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                else if (imem_rsp_valid)
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (redirect_valid | instr_ready)
                    state_nxt = en ? S_REQ : S_IDLE;
            end
            S_DROP: begin
                if (imem_rsp_valid) state_nxt = en ? S_REQ : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!rst_n) state_nxt = pending ? S_DROP : S_IDLE;
    end

    always_comb begin
        imem_req_valid = (state == S_REQ);
        imem_req_addr  = pc;
        pc_next        = instr_pc + XLEN'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= RESET_PC;
        end else begin
            if (redirect_valid)
                pc <= redirect_addr;
            else if (rsp_take)
                pc <= pc + XLEN'(1);
            if (rsp_take & ~redirect_valid) begin
                instr       <= imem_rsp_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end
            if ((state == S_HOLD) & (redirect_valid | instr_ready))
                instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall;
    assign stall = ((state == S_REQ) & ~req_hs) |
                   ((state == S_WAIT) & ~imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_redirects <= '0;
            perf_stalls    <= '0;
        end else begin
            if (redirect_valid && perf_redirects != 16'hFFFF)
                perf_redirects <= perf_redirects + 16'd1;
            if (stall && perf_stalls != 16'hFFFF)
                perf_stalls <= perf_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: two instances (RESET_PC 0 and 0x7FFFF).
// Expected values are hand-computed per scenario.
module tb_pc_fetch_unit;
    localparam int XLEN = 19;
    localparam logic [XLEN-1:0] RPC1 = 19'h7FFFF;

    logic clk = 1'b0;
    logic rst_n;
    logic en, ready, rsp_v, instr_ready, redir_v;
    logic [XLEN-1:0] rsp_d, redir_a;
    logic req_valid, instr_valid;
    logic [XLEN-1:0] req_addr, instr, instr_pc, pc_next;

    logic en1, ready1, rsp_v1, instr_ready1, redir_v1;
    logic [XLEN-1:0] rsp_d1, redir_a1;
    logic req_valid1, instr_valid1;
    logic [XLEN-1:0] req_addr1, instr1, instr_pc1, pc_next1;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_redirects, perf_stalls, perf_redirects1, perf_stalls1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.XLEN(XLEN), .RESET_PC(19'h0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .imem_req_valid(req_valid), .imem_req_addr(req_addr),
        .imem_req_ready(ready), .imem_rsp_valid(rsp_v),
        .imem_rsp_data(rsp_d), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .pc_next(pc_next),
        .instr_ready(instr_ready), .redirect_valid(redir_v),
`ifdef FETCH_PERF_CNT_EN
        .redirect_addr(redir_a),
        .perf_redirects(perf_redirects), .perf_stalls(perf_stalls)
`else
        .redirect_addr(redir_a)
`endif
    );

    pc_fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1),
        .imem_req_valid(req_valid1), .imem_req_addr(req_addr1),
        .imem_req_ready(ready1), .imem_rsp_valid(rsp_v1),
        .imem_rsp_data(rsp_d1), .instr_valid(instr_valid1),
        .instr(instr1), .instr_pc(instr_pc1), .pc_next(pc_next1),
        .instr_ready(instr_ready1), .redirect_valid(redir_v1),
`ifdef FETCH_PERF_CNT_EN
        .redirect_addr(redir_a1),
        .perf_redirects(perf_redirects1), .perf_stalls(perf_stalls1)
`else
        .redirect_addr(redir_a1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_valid, req_addr, instr_valid, instr, instr_pc} !==
            {1'b0, 19'h0, 1'b0, 19'h0, 19'h0}) begin
            errors++;
            $display("FAIL reset0 got v=%b a=%h iv=%b i=%h pc=%h exp 0,0,0,0,0",
                     req_valid, req_addr, instr_valid, instr, instr_pc);
        end
        checks++;
        if ({req_valid1, req_addr1, instr_valid1, instr1, instr_pc1} !==
            {1'b0, RPC1, 1'b0, 19'h0, RPC1}) begin
            errors++;
            $display("FAIL reset1 got v=%b a=%h iv=%b i=%h pc=%h exp 0,7ffff,0,0,7ffff",
                     req_valid1, req_addr1, instr_valid1, instr1, instr_pc1);
        end
    endtask

    task automatic test_reset_pc_wrap();
        rst_n = 1'b1;
        en1 = 1'b1;
        ready1 = 1'b1;
        tick();
        checks++;
        if ({req_valid1, req_addr1} !== {1'b1, RPC1}) begin
            errors++;
            $display("FAIL rpc_req got v=%b a=%h exp 1 7ffff", req_valid1, req_addr1);
        end
        tick();
        rsp_v1 = 1'b1;
        rsp_d1 = 19'h0F0F0;
        tick();
        rsp_v1 = 1'b0;
        en1 = 1'b0;
        checks++;
        if ({instr_valid1, instr1, instr_pc1, pc_next1, req_addr1} !==
            {1'b1, 19'h0F0F0, RPC1, 19'h0, 19'h0}) begin
            errors++;
            $display("FAIL rpc_wrap got iv=%b i=%h pc=%h nx=%h a=%h exp 1 0f0f0 7ffff 0 0",
                     instr_valid1, instr1, instr_pc1, pc_next1, req_addr1);
        end
    endtask

    task automatic test_basic_fetch();
        en = 1'b1;
        ready = 1'b1;
        tick();
        checks++;
        if ({req_valid, req_addr} !== {1'b1, 19'h0}) begin
            errors++;
            $display("FAIL basic_req got v=%b a=%h exp 1 0", req_valid, req_addr);
        end
        tick();
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait got v=%b exp 0", req_valid);
        end
        rsp_v = 1'b1;
        rsp_d = 19'h12345;
        tick();
        rsp_v = 1'b0;
        checks++;
        if ({instr_valid, instr, instr_pc, pc_next, req_addr} !==
            {1'b1, 19'h12345, 19'h0, 19'h1, 19'h1}) begin
            errors++;
            $display("FAIL basic_hold got iv=%b i=%h pc=%h nx=%h a=%h exp 1 12345 0 1 1",
                     instr_valid, instr, instr_pc, pc_next, req_addr);
        end
        tick();
        checks++;
        if ({instr_valid, instr, instr_pc, req_valid} !==
            {1'b1, 19'h12345, 19'h0, 1'b0}) begin
            errors++;
            $display("FAIL basic_stable got iv=%b i=%h pc=%h v=%b exp 1 12345 0 0",
                     instr_valid, instr, instr_pc, req_valid);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if ({instr_valid, req_valid, req_addr} !== {1'b0, 1'b1, 19'h1}) begin
            errors++;
            $display("FAIL basic_next got iv=%b v=%b a=%h exp 0 1 1",
                     instr_valid, req_valid, req_addr);
        end
    endtask

    task automatic test_wrap();
        ready = 1'b0;
        redir_v = 1'b1;
        redir_a = 19'h7FFFF;
        tick();
        redir_v = 1'b0;
        checks++;
        if ({req_valid, req_addr} !== {1'b1, 19'h7FFFF}) begin
            errors++;
            $display("FAIL req_redirect got v=%b a=%h exp 1 7ffff", req_valid, req_addr);
        end
        ready = 1'b1;
        tick();
        rsp_v = 1'b1;
        rsp_d = 19'h0ABCD;
        tick();
        rsp_v = 1'b0;
        checks++;
        if ({instr, instr_pc, pc_next, req_addr} !==
            {19'h0ABCD, 19'h7FFFF, 19'h0, 19'h0}) begin
            errors++;
            $display("FAIL wrap got i=%h pc=%h nx=%h a=%h exp 0abcd 7ffff 0 0",
                     instr, instr_pc, pc_next, req_addr);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        tick();
        redir_v = 1'b1;
        redir_a = 19'h00100;
        tick();
        redir_v = 1'b0;
        checks++;
        if ({req_valid, req_addr} !== {1'b0, 19'h00100}) begin
            errors++;
            $display("FAIL drop got v=%b a=%h exp 0 100", req_valid, req_addr);
        end
        tick();
        rsp_v = 1'b1;
        rsp_d = 19'hDEAD0;
        tick();
        rsp_v = 1'b0;
        checks++;
        if ({instr_valid, req_valid, req_addr} !== {1'b0, 1'b1, 19'h00100}) begin
            errors++;
            $display("FAIL stale got iv=%b v=%b a=%h exp 0 1 100",
                     instr_valid, req_valid, req_addr);
        end
        tick();
        rsp_v = 1'b1;
        rsp_d = 19'h11111;
        tick();
        rsp_v = 1'b0;
        checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 19'h11111, 19'h00100}) begin
            errors++;
            $display("FAIL after_drop got iv=%b i=%h pc=%h exp 1 11111 100",
                     instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_redirect_hold();
        redir_v = 1'b1;
        redir_a = 19'h5;
        tick();
        redir_v = 1'b0;
        checks++;
        if ({instr_valid, req_valid, req_addr} !== {1'b0, 1'b1, 19'h5}) begin
            errors++;
            $display("FAIL hold_redir got iv=%b v=%b a=%h exp 0 1 5",
                     instr_valid, req_valid, req_addr);
        end
        tick();
        rsp_v = 1'b1;
        rsp_d = 19'h55555;
        tick();
        rsp_v = 1'b0;
        checks++;
        if ({instr_pc, pc_next, req_addr} !== {19'h5, 19'h6, 19'h6}) begin
            errors++;
            $display("FAIL hold5 got pc=%h nx=%h a=%h exp 5 6 6",
                     instr_pc, pc_next, req_addr);
        end
        instr_ready = 1'b1;
        redir_v = 1'b1;
        redir_a = 19'h00040;
        tick();
        instr_ready = 1'b0;
        redir_v = 1'b0;
        checks++;
        if ({instr_valid, req_valid, req_addr} !== {1'b0, 1'b1, 19'h00040}) begin
            errors++;
            $display("FAIL redir_prio got iv=%b v=%b a=%h exp 0 1 40",
                     instr_valid, req_valid, req_addr);
        end
    endtask

    task automatic test_stall_and_idle();
`ifdef FETCH_PERF_CNT_EN
        logic [15:0] s0;
        s0 = perf_stalls;
`endif
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({req_valid, req_addr} !== {1'b1, 19'h00040}) begin
                errors++;
                $display("FAIL stall%0d got v=%b a=%h exp 1 40", i, req_valid, req_addr);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_stalls < s0 + 16'd4) begin
            errors++;
            $display("FAIL perf_stalls got %0d exp >= %0d", perf_stalls, s0 + 16'd4);
        end
`endif
        ready = 1'b1;
        tick();
        rsp_v = 1'b1;
        rsp_d = 19'h22222;
        tick();
        rsp_v = 1'b0;
        instr_ready = 1'b1;
        en = 1'b0;
        tick();
        instr_ready = 1'b0;
        checks++;
        if ({req_valid, instr_valid, instr} !== {1'b0, 1'b0, 19'h22222}) begin
            errors++;
            $display("FAIL to_idle got v=%b iv=%b i=%h exp 0 0 22222",
                     req_valid, instr_valid, instr);
        end
        redir_v = 1'b1;
        redir_a = 19'h00077;
        tick();
        redir_v = 1'b0;
        checks++;
        if ({req_valid, req_addr} !== {1'b0, 19'h00077}) begin
            errors++;
            $display("FAIL idle_redir got v=%b a=%h exp 0 77", req_valid, req_addr);
        end
        en = 1'b1;
        tick();
        checks++;
        if ({req_valid, req_addr} !== {1'b1, 19'h00077}) begin
            errors++;
            $display("FAIL idle_en got v=%b a=%h exp 1 77", req_valid, req_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({req_valid, req_addr, instr_valid, instr, instr_pc} !==
            {1'b0, 19'h0, 1'b0, 19'h0, 19'h0}) begin
            errors++;
            $display("FAIL rst_wait got v=%b a=%h iv=%b i=%h pc=%h exp 0 0 0 0 0",
                     req_valid, req_addr, instr_valid, instr, instr_pc);
        end
        tick();
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_drain got v=%b exp 0", req_valid);
        end
        rsp_v = 1'b1;
        rsp_d = 19'h0BAD0;
        tick();
        rsp_v = 1'b0;
        checks++;
        if ({instr_valid, req_valid, req_addr} !== {1'b0, 1'b1, 19'h0}) begin
            errors++;
            $display("FAIL rst_late got iv=%b v=%b a=%h exp 0 1 0",
                     instr_valid, req_valid, req_addr);
        end
        tick();
        rsp_v = 1'b1;
        rsp_d = 19'h33333;
        tick();
        rsp_v = 1'b0;
        checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 19'h33333, 19'h0}) begin
            errors++;
            $display("FAIL rst_refetch got iv=%b i=%h pc=%h exp 1 33333 0",
                     instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_redirect_with_rsp();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        rsp_v = 1'b1;
        rsp_d = 19'h0EEEE;
        redir_v = 1'b1;
        redir_a = 19'h00200;
        tick();
        rsp_v = 1'b0;
        redir_v = 1'b0;
        checks++;
        if ({instr_valid, instr, req_valid, req_addr} !==
            {1'b0, 19'h33333, 1'b1, 19'h00200}) begin
            errors++;
            $display("FAIL redir_rsp got iv=%b i=%h v=%b a=%h exp 0 33333 1 200",
                     instr_valid, instr, req_valid, req_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_redirects !== 16'd1) begin
            errors++;
            $display("FAIL perf_redirects got %0d exp 1", perf_redirects);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        {en, ready, rsp_v, instr_ready, redir_v} = '0;
        rsp_d = '0;
        redir_a = '0;
        {en1, ready1, rsp_v1, instr_ready1, redir_v1} = '0;
        rsp_d1 = '0;
        redir_a1 = '0;
        test_reset();
        test_reset_pc_wrap();
        test_basic_fetch();
        test_wrap();
        test_redirect_wait();
        test_redirect_hold();
        test_stall_and_idle();
        test_reset_in_wait();
        test_redirect_with_rsp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
